// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell walks the operand shifters LSB first,
// with valid/ready handshakes on both the operand and result sides.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             bit_s;
  logic             maj_s;
  logic [WIDTH-1:0] sh_next;

  always_comb begin
    bit_s = a_q[0] ^ b_q[0] ^ carry_q;
    maj_s = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    // Written as shift-then-insert so WIDTH=1 needs no empty slice.
    sh_next            = sh_q >> 1;
    sh_next[WIDTH-1]   = bit_s;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = maj_s;
        sh_d    = sh_next;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = sh_next;
          cout_d  = maj_s;
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StHold);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded directed bench for serial_adder: WIDTH=8 directed cases plus
// exhaustive sweeps of WIDTH=4 and WIDTH=1 instances.
module tb_serial_adder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, cin8, co8;
  logic [7:0] a8, b8, s8;
  logic       iv4, ir4, ov4, or4, cin4, co4;
  logic [3:0] a4, b4, s4;
  logic       iv1, ir1, ov1, or1, cin1, co1;
  logic [0:0] a1, b1, s1;

  logic [8:0] sb[$];
  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
  );
  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4)
  );
  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ovw(input int w);
    return (w == 8) ? ov8 : (w == 4) ? ov4 : ov1;
  endfunction

  function automatic logic irw(input int w);
    return (w == 8) ? ir8 : (w == 4) ? ir4 : ir1;
  endfunction

  function automatic logic [8:0] resw(input int w);
    if (w == 8) return {co8, s8};
    if (w == 4) return {4'b0, co4, s4};
    return {7'b0, co1, s1};
  endfunction

  task automatic drive(input int w, input logic [7:0] x, input logic [7:0] y, input logic c,
                       input logic v);
    if (w == 8) begin
      a8 = x; b8 = y; cin8 = c; iv8 = v;
    end else if (w == 4) begin
      a4 = x[3:0]; b4 = y[3:0]; cin4 = c; iv4 = v;
    end else begin
      a1 = x[0]; b1 = y[0]; cin1 = c; iv1 = v;
    end
  endtask

  task automatic set_or(input int w, input logic r);
    if (w == 8) or8 = r;
    else if (w == 4) or4 = r;
    else or1 = r;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input int w, input logic [7:0] x, input logic [7:0] y, input logic c,
                        input int stall_in, input bit rand_stall, input bit noise);
    logic [8:0] exp, held, mask;
    int n, stall;
    mask = (9'(1) << (w + 1)) - 9'(1);
    exp  = (9'(x) + 9'(y) + 9'(c)) & mask;
    chk("in_ready_idle", 32'(irw(w)), 1);
    held = resw(w);
    drive(w, x, y, c, 1'b1);
    sb.push_back(exp);
    @(negedge clk);
    drive(w, x, y, c, 1'b0);
    n = 0;
    while (!ovw(w) && n < w + 4) begin
      chk("in_ready_run", 32'(irw(w)), 0);
      chk("sum_stable_run", 32'(resw(w)), 32'(held));
      // Operand changes while busy must not leak into the running addition.
      if (noise) drive(w, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), n[0]);
      @(negedge clk);
      n++;
    end
    drive(w, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("latency", 32'(n), 32'(w));
    exp = sb.pop_front();
    chk("result", 32'(resw(w)), 32'(exp));
    stall = rand_stall ? $urandom_range(0, 3) : stall_in;
    set_or(w, 1'b0);
    repeat (stall) begin
      @(negedge clk);
      chk("hold_valid", 32'(ovw(w)), 1);
      chk("hold_in_ready", 32'(irw(w)), 0);
      chk("hold_stable", 32'(resw(w)), 32'(exp));
    end
    set_or(w, 1'b1);
    @(negedge clk);
    set_or(w, 1'b0);
    chk("release_in_ready", 32'(irw(w)), 1);
    chk("release_valid", 32'(ovw(w)), 0);
    chk("release_sum_kept", 32'(resw(w)), 32'(exp));
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen_valid;
    reset = 1'b0;
    drive(8, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(4, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1, 8'h00, 8'h00, 1'b0, 1'b0);
    or8 = 1'b0; or4 = 1'b0; or1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(ir8), 1);
    chk("rst_out_valid", 32'(ov8), 0);
    chk("rst_result", 32'({co8, s8}), 0);
    chk("rst_in_ready_w1", 32'(ir1), 1);
    reset = 1'b1;
    @(negedge clk);

    run_op(8, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    run_op(8, 8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    run_op(8, 8'hA5, 8'h5A, 1'b1, 0, 1'b0, 1'b0);
    run_op(8, 8'h3C, 8'h42, 1'b0, 0, 1'b0, 1'b0);
    run_op(8, 8'h80, 8'h80, 1'b1, 5, 1'b0, 1'b0);
    run_op(8, 8'h5A, 8'hC3, 1'b1, 1, 1'b0, 1'b1);

    // Abort on the third RUN edge: result is discarded and registers clear.
    drive(8, 8'hFF, 8'hFF, 1'b1, 1'b1);
    sb.push_back(9'h1FF);
    @(negedge clk);
    drive(8, 8'hFF, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    void'(sb.pop_front());
    chk("abort_in_ready", 32'(ir8), 1);
    chk("abort_out_valid", 32'(ov8), 0);
    chk("abort_result", 32'({co8, s8}), 0);
    seen_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ov8) seen_valid = 1'b1;
    end
    chk("abort_no_valid", 32'(seen_valid), 0);
    run_op(8, 8'h12, 8'h34, 1'b0, 0, 1'b0, 1'b0);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          run_op(4, 8'(x), 8'(y), 1'(c), 0, 1'b1, 1'b0);
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        for (int c = 0; c < 2; c++)
          run_op(1, 8'(x), 8'(y), 1'(c), 0, 1'b1, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
